// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D-cache to physical-memory arbiter.
// States are plain logic constants so older netlists and dumps decode them unchanged.
package cache_arbiter_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE    = 2'd0;
  localparam arb_state_t SERVE_A = 2'd1;
  localparam arb_state_t SERVE_B = 2'd2;
  localparam arb_state_t DONE    = 2'd3;

  // B wins ties unless A has been passed over often enough to hit the starvation limit.
  function automatic arb_state_t grant_state(
    input logic a_pend,
    input logic b_pend,
    input logic at_limit
  );
    arb_state_t g;
    if (a_pend && (!b_pend || at_limit)) begin
      g = SERVE_A;
    end else if (b_pend) begin
      g = SERVE_B;
    end else begin
      g = IDLE;
    end
    return g;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Requester and memory-side signals of the cache arbiter.
// slave = arbiter side, master = caches plus memory model.
interface cache_arbiter_if #(
  parameter int LINE_WIDTH = 256
);

  logic                  a_read;
  logic [31:0]           a_addr;
  logic [LINE_WIDTH-1:0] a_rdata;
  logic                  a_resp;

  logic                  b_read;
  logic                  b_write;
  logic [31:0]           b_addr;
  logic [LINE_WIDTH-1:0] b_wdata;
  logic [LINE_WIDTH-1:0] b_rdata;
  logic                  b_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [31:0]           pmem_addr;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  a_read, a_addr, b_read, b_write, b_addr, b_wdata, pmem_rdata, pmem_resp,
    output a_rdata, a_resp, b_rdata, b_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output a_read, a_addr, b_read, b_write, b_addr, b_wdata, pmem_rdata, pmem_resp,
    input  a_rdata, a_resp, b_rdata, b_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_starve_counter.sv
// Saturating count of consecutive B grants taken while A was waiting.
// at_limit tells the arbiter that A must win the next tie.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_r;

  // Count B grants over a waiting A; clear takes precedence, saturate at the limit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {CW{1'b0}};
    end else if (clr) begin
      cnt_r <= {CW{1'b0}};
    end else if (inc && (cnt_r != LIMIT_C)) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_limit = (cnt_r == LIMIT_C);

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates one cache-line transaction at a time between the I-cache (A) and D-cache (B)
// onto the single physical-memory port; B has priority, A is protected from starvation.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int LINE_WIDTH   = 256,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            reset,
  cache_arbiter_if.slave bus
);

  arb_state_t            state_r;
  arb_state_t            state_s;
  logic                  read_r;
  logic                  write_r;
  logic [31:0]           addr_r;
  logic [LINE_WIDTH-1:0] wdata_r;

  logic a_pend_s;
  logic b_pend_s;
  logic at_limit_s;
  logic grant_a_s;
  logic grant_b_s;
  logic serving_s;
  logic cnt_inc_s;
  logic cnt_clr_s;

  assign a_pend_s  = bus.a_read;
  assign b_pend_s  = bus.b_read | bus.b_write;
  assign serving_s = (state_r == SERVE_A) || (state_r == SERVE_B);

  // Next-state logic: arbitrate in IDLE, wait for memory, then one bubble cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        state_s = grant_state(a_pend_s, b_pend_s, at_limit_s);
      end
      SERVE_A, SERVE_B: begin
        if (bus.pmem_resp) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign grant_a_s = (state_r == IDLE) && (state_s == SERVE_A);
  assign grant_b_s = (state_r == IDLE) && (state_s == SERVE_B);
  assign cnt_inc_s = grant_b_s & bus.a_read;
  assign cnt_clr_s = grant_a_s | ((state_r == IDLE) & ~bus.a_read);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the granted request so later requester activity cannot disturb the memory command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= {LINE_WIDTH{1'b0}};
    end else if (grant_a_s) begin
      read_r  <= 1'b1;
      write_r <= 1'b0;
      addr_r  <= bus.a_addr;
      wdata_r <= wdata_r;
    end else if (grant_b_s) begin
      // A simultaneous read+write from the D-cache is a write-back.
      read_r  <= ~bus.b_write;
      write_r <= bus.b_write;
      addr_r  <= bus.b_addr;
      wdata_r <= bus.b_wdata;
    end else if (serving_s && bus.pmem_resp) begin
      read_r  <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end else begin
      read_r  <= read_r;
      write_r <= write_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  arb_starve_counter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (cnt_inc_s),
    .clr      (cnt_clr_s),
    .at_limit (at_limit_s)
  );

  assign bus.pmem_read  = read_r;
  assign bus.pmem_write = write_r;
  assign bus.pmem_addr  = addr_r;
  assign bus.pmem_wdata = wdata_r;

  // Response and fill data pass straight through so the stalled stage releases with no added latency.
  assign bus.a_resp  = (state_r == SERVE_A) & bus.pmem_resp;
  assign bus.b_resp  = (state_r == SERVE_B) & bus.pmem_resp;
  assign bus.a_rdata = bus.pmem_rdata;
  assign bus.b_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: tests queue expected transactions, a negedge monitor
// pops one per resp pulse, and a small memory model answers commands after mem_lat cycles.
module tb_cache_arbiter;
  import cache_arbiter_pkg::*;

  localparam int LW = 256;

  typedef struct {
    logic          is_b;
    logic          is_write;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  int            mem_lat    = 5;
  logic          mem_auto   = 1'b1;
  logic [LW-1:0] mem_data   = '0;
  int            inject_req = 0;
  int            inject_done = 0;

  cache_arbiter_if #(.LINE_WIDTH(LW)) bus ();

  cache_arbiter #(
    .LINE_WIDTH   (LW),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: answer a held command after mem_lat cycles, or inject a stray response on request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (inject_done != inject_req) begin
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = mem_data;
        inject_done++;
      end else if (bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        wait_cnt = 0;
      end else if (mem_auto && (bus.pmem_read || bus.pmem_write)) begin
        wait_cnt++;
        if (wait_cnt >= mem_lat) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = mem_data;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard monitor: every resp pulse must match the next queued transaction.
  initial begin
    exp_t          e;
    logic [LW-1:0] rd;
    forever begin
      @(negedge clk);
      if (bus.a_resp || bus.b_resp) begin
        checks++;
        if (bus.a_resp && bus.b_resp) begin
          errors++;
          $display("FAIL both_resp a_resp=%b b_resp=%b required one-hot", bus.a_resp, bus.b_resp);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp a_resp=%b b_resp=%b required none", bus.a_resp, bus.b_resp);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (bus.b_resp !== e.is_b) begin
            errors++;
            $display("FAIL resp_port got b_resp=%b required %b", bus.b_resp, e.is_b);
          end
          checks++;
          if (bus.pmem_write !== e.is_write) begin
            errors++;
            $display("FAIL resp_cmd got pmem_write=%b required %b", bus.pmem_write, e.is_write);
          end
          checks++;
          if (bus.pmem_addr !== e.addr) begin
            errors++;
            $display("FAIL resp_addr got %h required %h", bus.pmem_addr, e.addr);
          end
          checks++;
          if (e.is_write) begin
            if (bus.pmem_wdata !== e.wdata) begin
              errors++;
              $display("FAIL resp_wdata got %h required %h", bus.pmem_wdata, e.wdata);
            end
          end else begin
            rd = e.is_b ? bus.b_rdata : bus.a_rdata;
            if (rd !== e.rdata) begin
              errors++;
              $display("FAIL resp_rdata got %h required %h", rd, e.rdata);
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input logic is_b, input logic is_write, input logic [31:0] addr,
                          input logic [LW-1:0] wdata, input logic [LW-1:0] rdata);
    exp_t e;
    e.is_b = is_b; e.is_write = is_write; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input logic want_b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (want_b ? bus.b_resp : bus.a_resp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.a_read = 1'b0; bus.a_addr = '0;
    bus.b_read = 1'b0; bus.b_write = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.pmem_read, bus.pmem_write, bus.a_resp, bus.b_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_cmds got %b required 0000", {bus.pmem_read, bus.pmem_write, bus.a_resp, bus.b_resp});
    end
    checks++;
    if (bus.pmem_addr !== 32'h0 || bus.pmem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h required 0", bus.pmem_addr, bus.pmem_wdata);
    end
    checks++;
    if (dut.state_r !== IDLE || dut.u_starve.cnt_r !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got state=%0d cnt=%0d required 0/0", dut.state_r, dut.u_starve.cnt_r);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_lone_a_read();
    bit ok;
    mem_lat = 5;
    mem_data = {32{8'hA5}};
    push_exp(1'b0, 1'b0, 32'h0000_1000, '0, {32{8'hA5}});
    @(posedge clk); #1;
    bus.a_read = 1'b1; bus.a_addr = 32'h0000_1000;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0 || bus.pmem_addr !== 32'h0000_1000) begin
      errors++;
      $display("FAIL a_cmd got rd=%b wr=%b addr=%h required 1 0 00001000", bus.pmem_read, bus.pmem_write, bus.pmem_addr);
    end
    wait_resp(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL a_resp_timeout got none required a_resp"); end
    @(posedge clk); #1 bus.a_read = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_r !== DONE || bus.pmem_read !== 1'b0 || bus.a_resp !== 1'b0) begin
      errors++;
      $display("FAIL a_done got state=%0d rd=%b resp=%b required 3 0 0", dut.state_r, bus.pmem_read, bus.a_resp);
    end
    @(negedge clk);
    checks++;
    if (dut.state_r !== IDLE) begin
      errors++;
      $display("FAIL a_idle got state=%0d required 0", dut.state_r);
    end
  endtask

  task automatic test_lone_b_write();
    bit ok;
    logic [LW-1:0] w1;
    w1 = {8{32'h1234_5678}};
    mem_lat = 3;
    push_exp(1'b1, 1'b1, 32'h0000_2000, w1, '0);
    @(posedge clk); #1;
    bus.b_write = 1'b1; bus.b_addr = 32'h0000_2000; bus.b_wdata = w1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== w1) begin
      errors++;
      $display("FAIL b_wr_cmd got wr=%b rd=%b wdata=%h required 1 0 %h", bus.pmem_write, bus.pmem_read, bus.pmem_wdata, w1);
    end
    @(posedge clk); #1 bus.b_wdata = ~w1;
    @(negedge clk);
    checks++;
    if (bus.pmem_wdata !== w1) begin
      errors++;
      $display("FAIL b_wdata_latched got %h required %h", bus.pmem_wdata, w1);
    end
    wait_resp(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b_resp_timeout got none required b_resp"); end
    @(posedge clk); #1 bus.b_write = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_simultaneous();
    bit ok;
    mem_lat = 2;
    mem_data = {8{32'hDEAD_BEEF}};
    push_exp(1'b1, 1'b0, 32'h0000_3000, '0, {8{32'hDEAD_BEEF}});
    push_exp(1'b0, 1'b0, 32'h0000_4000, '0, {8{32'hDEAD_BEEF}});
    @(posedge clk); #1;
    bus.a_read = 1'b1; bus.a_addr = 32'h0000_4000;
    bus.b_read = 1'b1; bus.b_addr = 32'h0000_3000;
    wait_resp(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sim_b_timeout got none required b_resp"); end
    @(posedge clk); #1 bus.b_read = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.state_r !== DONE || bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL sim_bubble got state=%0d rd=%b wr=%b required 3 0 0", dut.state_r, bus.pmem_read, bus.pmem_write);
    end
    @(negedge clk);
    checks++;
    if (dut.state_r !== IDLE || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL sim_idle got state=%0d rd=%b required 0 0", dut.state_r, bus.pmem_read);
    end
    @(negedge clk);
    checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_addr !== 32'h0000_4000) begin
      errors++;
      $display("FAIL sim_a_cmd got rd=%b addr=%h required 1 00004000", bus.pmem_read, bus.pmem_addr);
    end
    wait_resp(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sim_a_timeout got none required a_resp"); end
    @(posedge clk); #1 bus.a_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_starvation();
    bit ok;
    mem_lat = 2;
    mem_data = {8{32'h0BAD_F00D}};
    for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b0, 32'h0000_5000, '0, {8{32'h0BAD_F00D}});
    push_exp(1'b0, 1'b0, 32'h0000_6000, '0, {8{32'h0BAD_F00D}});
    @(posedge clk); #1;
    bus.a_read = 1'b1; bus.a_addr = 32'h0000_6000;
    bus.b_read = 1'b1; bus.b_addr = 32'h0000_5000;
    for (int i = 0; i < 4; i++) begin
      wait_resp(1'b1, ok);
      checks++;
      if (!ok || dut.u_starve.cnt_r !== 3'(i + 1)) begin
        errors++;
        $display("FAIL starve_b%0d got ok=%b cnt=%0d required 1 %0d", i, ok, dut.u_starve.cnt_r, i + 1);
      end
    end
    wait_resp(1'b0, ok);
    checks++;
    if (!ok || dut.u_starve.cnt_r !== 3'd0) begin
      errors++;
      $display("FAIL starve_a got ok=%b cnt=%0d required 1 0", ok, dut.u_starve.cnt_r);
    end
    @(posedge clk); #1;
    bus.a_read = 1'b0; bus.b_read = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    mem_auto = 1'b0;
    @(posedge clk); #1;
    bus.b_write = 1'b1; bus.b_addr = 32'h0000_7000; bus.b_wdata = {8{32'hFACE_CAFE}};
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.pmem_write !== 1'b1 || dut.state_r !== SERVE_B) begin
      errors++;
      $display("FAIL rst_pre got wr=%b state=%0d required 1 2", bus.pmem_write, dut.state_r);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (bus.pmem_write !== 1'b0 || dut.state_r !== IDLE || bus.pmem_wdata !== '0) begin
      errors++;
      $display("FAIL rst_async got wr=%b state=%0d required 0 0", bus.pmem_write, dut.state_r);
    end
    bus.b_write = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    inject_req++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.a_resp !== 1'b0 || bus.b_resp !== 1'b0) begin
        errors++;
        $display("FAIL rst_stray got a=%b b=%b required 0 0", bus.a_resp, bus.b_resp);
      end
    end
    checks++;
    if (dut.state_r !== IDLE || bus.pmem_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got state=%0d wr=%b required 0 0", dut.state_r, bus.pmem_write);
    end
    mem_auto = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_conflict_drop();
    bit ok;
    logic [LW-1:0] w2;
    w2 = {8{32'h5555_AAAA}};
    mem_lat = 3;
    mem_data = {8{32'hC0FF_EE00}};
    push_exp(1'b1, 1'b1, 32'h0000_8000, w2, '0);
    @(posedge clk); #1;
    bus.b_read = 1'b1; bus.b_write = 1'b1; bus.b_addr = 32'h0000_8000; bus.b_wdata = w2;
    @(negedge clk); @(negedge clk);
    checks++;
    if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin
      errors++;
      $display("FAIL rw_cmd got wr=%b rd=%b required 1 0", bus.pmem_write, bus.pmem_read);
    end
    wait_resp(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rw_timeout got none required b_resp"); end
    @(posedge clk); #1;
    bus.b_read = 1'b0; bus.b_write = 1'b0;
    repeat (2) @(posedge clk);
    push_exp(1'b0, 1'b0, 32'h0000_9000, '0, {8{32'hC0FF_EE00}});
    #1 bus.a_read = 1'b1; bus.a_addr = 32'h0000_9000;
    @(posedge clk); @(posedge clk);
    #1 bus.a_read = 1'b0;
    wait_resp(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL drop_timeout got none required a_resp"); end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_lone_a_read();
    test_lone_b_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_conflict_drop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
